// File: rtl/bar_pkg.sv
// Shared widths, column map, FSM encoding and bar record layout for the
// market-data fetch controller.
package bar_pkg;

    localparam int unsigned ROW_W    = 10;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_COLS = 6;
    localparam int unsigned BAR_W    = NUM_COLS * DATA_W;
    localparam int unsigned COL_W    = 3;
    localparam int unsigned CNT_W    = ROW_W + 1;

    localparam logic [COL_W-1:0] COL_TIMESTAMP = 3'd0;
    localparam logic [COL_W-1:0] COL_OPEN      = 3'd1;
    localparam logic [COL_W-1:0] COL_HIGH      = 3'd2;
    localparam logic [COL_W-1:0] COL_LOW       = 3'd3;
    localparam logic [COL_W-1:0] COL_CLOSE     = 3'd4;
    localparam logic [COL_W-1:0] COL_VOLUME    = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Column 0 lands in the least significant word.
    typedef struct packed {
        logic [DATA_W-1:0] volume;
        logic [DATA_W-1:0] close;
        logic [DATA_W-1:0] low;
        logic [DATA_W-1:0] high;
        logic [DATA_W-1:0] open;
        logic [DATA_W-1:0] timestamp;
    } bar_rec_t;

    // Row increment with natural wrap 1023 -> 0.
    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
        return r + ROW_W'(1);
    endfunction

endpackage

// File: rtl/bar_fetch_ctrl_if.sv
// Request, BRAM and bar-stream signals of the fetch controller.
interface bar_fetch_ctrl_if;
    import bar_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ROW_W-1:0]  req_row;
    logic [CNT_W-1:0]  req_count;

    logic [ROW_W-1:0]  mem_row_index;
    logic [COL_W-1:0]  mem_col_index;
    logic [DATA_W-1:0] mem_data;

    logic              bar_valid;
    logic              bar_ready;
    logic [BAR_W-1:0]  bar_data;
    logic [ROW_W-1:0]  bar_row;
    logic              bar_last;

    logic              busy;
    logic              done;

    modport master (
        output req_valid, req_row, req_count, mem_data, bar_ready,
        input  req_ready, mem_row_index, mem_col_index,
               bar_valid, bar_data, bar_row, bar_last, busy, done
    );

    modport slave (
        input  req_valid, req_row, req_count, mem_data, bar_ready,
        output req_ready, mem_row_index, mem_col_index,
               bar_valid, bar_data, bar_row, bar_last, busy, done
    );

endinterface

// File: rtl/bar_capture.sv
// Delays (issue-active, column) by one cycle to line up with the BRAM's
// registered read and loads the matching slot of the bar record.
module bar_capture
    import bar_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_i,
    input  logic [COL_W-1:0]  col_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [BAR_W-1:0]  bar_data_o
);

    logic             act_q;
    logic [COL_W-1:0] col_q;
    bar_rec_t         rec_q;
    bar_rec_t         rec_d;

    always_comb begin
        rec_d = rec_q;
        if (act_q) begin
            case (col_q)
                COL_TIMESTAMP: rec_d.timestamp = mem_data_i;
                COL_OPEN:      rec_d.open      = mem_data_i;
                COL_HIGH:      rec_d.high      = mem_data_i;
                COL_LOW:       rec_d.low       = mem_data_i;
                COL_CLOSE:     rec_d.close     = mem_data_i;
                COL_VOLUME:    rec_d.volume    = mem_data_i;
                default:       rec_d           = rec_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q <= 1'b0;
            col_q <= '0;
            rec_q <= '0;
        end else begin
            act_q <= issue_i;
            col_q <= col_i;
            rec_q <= rec_d;
        end
    end

    assign bar_data_o = rec_q;

endmodule

// File: rtl/bar_fetch_ctrl.sv
// Burst sequencer: walks rows of the market-data BRAM column by column and
// streams each assembled row downstream as one bar record.
module bar_fetch_ctrl
    import bar_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    bar_fetch_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [ROW_W-1:0]  bar_row_q, bar_row_d;
    logic              bar_valid_q, bar_valid_d;
    logic              bar_last_q, bar_last_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              req_ready_q, req_ready_d;
    logic              issue_c;

    assign issue_c = (state_q == S_ISSUE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            remaining_q <= '0;
            bar_row_q   <= '0;
            bar_valid_q <= 1'b0;
            bar_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            remaining_q <= remaining_d;
            bar_row_q   <= bar_row_d;
            bar_valid_q <= bar_valid_d;
            bar_last_q  <= bar_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Addresses are the row/col counters themselves, so they hold in IDLE and HOLD.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        remaining_d = remaining_q;
        bar_row_d   = bar_row_q;
        bar_valid_d = bar_valid_q;
        bar_last_d  = bar_last_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    if (bus.req_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        row_d       = bus.req_row;
                        remaining_d = bus.req_count;
                        col_d       = COL_TIMESTAMP;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (col_q == COL_VOLUME) begin
                    state_d = S_DRAIN;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_DRAIN: begin
                bar_valid_d = 1'b1;
                bar_last_d  = (remaining_q == CNT_W'(1));
                bar_row_d   = row_q;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (bus.bar_ready) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    bar_valid_d = 1'b0;
                    bar_last_d  = 1'b0;
                    if (remaining_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        row_d   = next_row(row_q);
                        col_d   = COL_TIMESTAMP;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
    end

    bar_capture u_capture (
        .clk        (clk),
        .reset      (reset),
        .issue_i    (issue_c),
        .col_i      (col_q),
        .mem_data_i (bus.mem_data),
        .bar_data_o (bus.bar_data)
    );

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_row_index = row_q;
    assign bus.mem_col_index = col_q;
    assign bus.bar_valid     = bar_valid_q;
    assign bus.bar_row       = bar_row_q;
    assign bus.bar_last      = bar_last_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_bar_fetch_ctrl.sv
// Self-checking bench for bar_fetch_ctrl with a BRAM model and a burst-level reference.
module tb_bar_fetch_ctrl;
    import bar_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bar_fetch_ctrl_if bus();

    bar_fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [1024][NUM_COLS];
    int errors = 0;
    int checks = 0;

    // 1-cycle registered-read BRAM model.
    always @(posedge clk) begin
        if (int'(bus.mem_col_index) < int'(NUM_COLS))
            bus.mem_data <= mem[bus.mem_row_index][bus.mem_col_index];
        else
            bus.mem_data <= 32'hDEAD_BEEF;
    end

    typedef struct {
        int unsigned  row;
        int unsigned  count;
        int unsigned  stall;
        bit           rnd;
        int unsigned  exp_first_row;
        int unsigned  exp_last_row;
        bit           chk_data;
        logic [191:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [191:0] model_bar(input int unsigned row);
        logic [191:0] e;
        for (int c = 0; c < 6; c++) e[c*32 +: 32] = mem[row][c];
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, " bar_valid"}, 32'(bus.bar_valid), 32'd0);
        chk({tag, " bar_last"},  32'(bus.bar_last), 32'd0);
        chk({tag, " done"},      32'(bus.done), 32'd0);
        chk({tag, " busy"},      32'(bus.busy), 32'd0);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, " bar_row"},   32'(bus.bar_row), 32'd0);
        chk({tag, " mem_row"},   32'(bus.mem_row_index), 32'd0);
        chk({tag, " mem_col"},   32'(bus.mem_col_index), 32'd0);
        chkw({tag, " bar_data"}, bus.bar_data, 192'd0);
    endtask

    // Issue one burst from a negedge with the DUT idle and follow it to completion.
    task automatic run_burst(input int unsigned row, input int unsigned count,
                             input int unsigned stall, input bit rnd,
                             output int unsigned first_row, output int unsigned last_row,
                             output int unsigned nbars, output logic [191:0] first_data);
        int unsigned bar_idx = 0;
        int          start_j = 0;
        int          done_j  = (count == 0) ? 0 : -1;
        int unsigned stall_left = stall;
        bit          finished = 1'b0;
        bit          exp_valid, exp_busy, r;
        int unsigned exp_row, exp_col;
        first_row = 0; last_row = 0; nbars = 0; first_data = '0;

        chk("req_ready before request", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_row   = ROW_W'(row);
        bus.req_count = CNT_W'(count);
        bus.bar_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;

        for (int j = 0; j < 12000; j++) begin
            if (j > 0) @(negedge clk);
            exp_valid = (bar_idx < count) && (j >= start_j + 7);
            exp_row   = (row + bar_idx) % 1024;
            chk("bar_valid", 32'(bus.bar_valid), 32'(exp_valid));
            if (exp_valid && bus.bar_valid) begin
                chk("bar_row", 32'(bus.bar_row), exp_row);
                chk("bar_last", 32'(bus.bar_last), 32'(bar_idx == count - 1));
                chkw("bar_data", bus.bar_data, model_bar(exp_row));
                if (bar_idx == 0) begin
                    first_row  = 32'(bus.bar_row);
                    first_data = bus.bar_data;
                end
                last_row = 32'(bus.bar_row);
            end
            if (bar_idx < count) begin
                exp_col = (j - start_j > 5) ? 5 : j - start_j;
                chk("mem_row_index", 32'(bus.mem_row_index), exp_row);
                chk("mem_col_index", 32'(bus.mem_col_index), exp_col);
            end
            exp_busy = (count > 0) && (done_j < 0 || j < done_j);
            chk("done", 32'(bus.done), 32'(done_j >= 0 && j == done_j));
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("req_ready", 32'(bus.req_ready), 32'(!exp_busy));
            if (done_j >= 0 && j >= done_j + 1) begin
                finished = 1'b1;
                break;
            end
            if (rnd)                             r = ($urandom_range(0, 3) != 0);
            else if (exp_valid && stall_left > 0) begin r = 1'b0; stall_left--; end
            else                                 r = 1'b1;
            bus.bar_ready = r;
            if (exp_valid && r) begin
                nbars++;
                bar_idx++;
                start_j = j + 1;
                if (bar_idx == count) done_j = j + 1;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL burst timeout: row %0d count %0d not completed", row, count);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int unsigned fr, lr, nb;
        logic [191:0] fd;

        vecs[0] = '{5,    1,    0,  1'b0, 5,    5,    1'b1,
                    192'h66666666_55555555_44444444_33333333_22222222_11111111};
        vecs[1] = '{100,  4,    0,  1'b0, 100,  103,  1'b0, 192'd0};
        vecs[2] = '{300,  2,    20, 1'b0, 300,  301,  1'b0, 192'd0};
        vecs[3] = '{1022, 3,    0,  1'b0, 1022, 0,    1'b0, 192'd0};
        vecs[4] = '{0,    0,    0,  1'b0, 0,    0,    1'b0, 192'd0};
        vecs[5] = '{512,  1024, 0,  1'b0, 512,  511,  1'b0, 192'd0};

        for (int r = 0; r < 1024; r++)
            for (int c = 0; c < 6; c++) mem[r][c] = $urandom();
        for (int c = 0; c < 6; c++) mem[5][c] = 32'h11111111 * 32'(c + 1);

        bus.req_valid = 1'b0;
        bus.req_row   = '0;
        bus.req_count = '0;
        bus.bar_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i].row, vecs[i].count, vecs[i].stall, vecs[i].rnd, fr, lr, nb, fd);
            chk("bar count", nb, vecs[i].count);
            if (vecs[i].count > 0) begin
                chk("first bar_row", fr, vecs[i].exp_first_row);
                chk("last bar_row", lr, vecs[i].exp_last_row);
            end
            if (vecs[i].chk_data) chkw("single bar data", fd, vecs[i].exp_data);
        end

        for (int i = 0; i < 8; i++) begin
            int unsigned rrow = $urandom_range(0, 1023);
            int unsigned rcnt = $urandom_range(1, 5);
            run_burst(rrow, rcnt, 0, 1'b1, fr, lr, nb, fd);
            chk("random bar count", nb, rcnt);
        end

        // Abort a 5-row burst while row 2 is being issued.
        bus.req_valid = 1'b1;
        bus.req_row   = ROW_W'(10);
        bus.req_count = CNT_W'(5);
        bus.bar_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort busy", 32'(bus.busy), 32'd1);
        chk("abort mem_row", 32'(bus.mem_row_index), 32'd11);
        chk("abort mem_col", 32'(bus.mem_col_index), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid-burst reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("after reset");
        run_burst(200, 2, 0, 1'b0, fr, lr, nb, fd);
        chk("post-reset bar count", nb, 2);
        chk("post-reset last row", lr, 201);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
